// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM state type and line-level constants shared by the UART transmitter.
package uart_tx_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
  localparam int DATA_BITS = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with occupancy count and a registered full flag.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        push,
  input  logic        pop,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] count_q, count_d;
  logic full_q, full_d, do_push, do_pop;
  always_comb begin
    do_push = push && !full_q;
    do_pop = pop && count_q != '0;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    full_d = count_d == (AW+1)'(DEPTH);
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      full_q <= full_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= wdata;
  assign rdata = mem_q[rd_q];
  assign full = full_q;
  assign empty = count_q == '0;
  assign count = count_q;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 UART transmitter; define UART_TX_PARITY_EN to append an even-parity bit.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DELAY_FRAMES = 234,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         txValid,
  input  logic [7:0]                   txData,
  output logic                         txReady,
  output logic                         uartTx,
  output logic                         txBusy,
  output logic [$clog2(FIFO_DEPTH):0]  fifoCount
);
  localparam int BW = $clog2(DELAY_FRAMES);
  state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, head;
  logic tx_q, tx_d, pop, full, empty, bit_end;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .resetN(resetN), .push(txValid), .pop(pop), .wdata(txData),
    .rdata(head), .full(full), .empty(empty), .count(fifoCount)
  );
  assign bit_end = baud_q == BW'(DELAY_FRAMES - 1);
  always_comb begin
    state_d = state_q;
    baud_d = baud_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d = '0;
        if (!empty) begin
          pop = 1'b1;
          shift_d = head;
          state_d = START;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        baud_d = '0;
      end
      DATA: if (bit_end) begin
        baud_d = '0;
        shift_d = shift_q >> 1;
        bit_d = bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
        if (bit_q == 3'(DATA_BITS - 1)) state_d = PARITY;
`else
        if (bit_q == 3'(DATA_BITS - 1)) state_d = STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        baud_d = '0;
      end
`endif
      STOP: if (bit_end) begin
        state_d = IDLE;
        baud_d = '0;
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_TX_PARITY_EN
    par_d = pop ? ^head : par_q;
    tx_d = state_d == START ? START_LEVEL : state_d == DATA ? shift_d[0] :
           state_d == PARITY ? par_d : STOP_LEVEL;
`else
    tx_d = state_d == START ? START_LEVEL : state_d == DATA ? shift_d[0] : STOP_LEVEL;
`endif
  end
  // line is registered so the pin never glitches and idles high straight out of reset
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= STOP_LEVEL;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) par_q <= 1'b0;
    else par_q <= par_d;
`endif
  assign uartTx = tx_q;
  assign txReady = !full;
  assign txBusy = state_q != IDLE || !empty;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of reset, single frame, burst/full boundary, mid-frame reset and optional parity.
module tb_uart_tx;
  localparam int D = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, resetN = 1'b0, txValid = 1'b0;
  logic [7:0] txData = 8'h00;
  logic txReady, uartTx, txBusy;
  logic [4:0] fifoCount;
  int n_vec = 0, n_miss = 0;

  always #5 clk = ~clk;

  uart_tx #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetN(resetN), .txValid(txValid), .txData(txData),
    .txReady(txReady), .uartTx(uartTx), .txBusy(txBusy), .fifoCount(fifoCount)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] frame_of(input logic [7:0] b);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < NB * D; i++) begin
      int k;
      k = i / D;
      f[i] = k == 0 ? 1'b0 : k <= 8 ? b[k-1] : (NB == 11 && k == 9) ? ^b : 1'b1;
    end
    return f;
  endfunction

  // gap = high negedge samples seen before the first low sample
  task automatic get_frame(output logic [63:0] obs, output int gap);
    obs = '0;
    gap = 0;
    @(negedge clk);
    while (uartTx !== 1'b0 && gap < 2000) begin
      gap++;
      @(negedge clk);
    end
    if (uartTx !== 1'b0) begin
      check("start_seen", uartTx, 0);
      return;
    end
    for (int i = 0; i < NB * D; i++) begin
      obs[i] = uartTx;
      if (i < NB * D - 1) @(negedge clk);
    end
  endtask

  task automatic push(input logic [7:0] b);
    logic rdy;
    int w;
    w = 0;
    txValid = 1'b1;
    txData = b;
    do begin
      rdy = txReady;
      @(posedge clk);
      #1;
      w++;
    end while (!rdy && w < 500);
    if (!rdy) check("push_accept", rdy, 1);
    txValid = 1'b0;
  endtask

  initial begin
    logic [63:0] obs;
    int gap;
    logic all_hi;
    repeat (5) begin
      @(negedge clk);
      txValid = 1'($urandom);
      txData = 8'($urandom);
      check("reset_state", {uartTx, txReady, txBusy, fifoCount}, {1'b1, 1'b1, 1'b0, 5'd0});
    end
    txValid = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    push(8'h55);
    check("single_count", fifoCount, 1);
    get_frame(obs, gap);
    check("single_latency", gap + 1, 2);
    check("single_frame", obs, frame_of(8'h55));
    check("single_busy_stop", txBusy, 1);
    @(negedge clk);
    check("single_busy_fall", {txBusy, uartTx}, {1'b0, 1'b1});

    fork
      begin
        for (int k = 0; k < 20; k++) begin
          logic rdy;
          logic [4:0] prev;
          int w;
          w = 0;
          prev = '0;
          txValid = 1'b1;
          txData = 8'(k);
          do begin
            rdy = txReady;
            prev = fifoCount;
            @(posedge clk);
            #1;
            w++;
          end while (!rdy && w < 500);
          if (!rdy) check("burst_accept", rdy, 1);
          if (k == 15) check("ready_before_full", txReady, 1);
          if (k == 16) check("full_after_17", {txReady, fifoCount}, {1'b0, 5'd16});
          if (k == 17) begin
            check("no_accept_on_pop_edge", prev, 15);
            check("refill_full", {txReady, fifoCount}, {1'b0, 5'd16});
          end
        end
        txValid = 1'b0;
      end
      begin
        for (int f = 0; f < 20; f++) begin
          get_frame(obs, gap);
          check($sformatf("burst_frame%0d", f), obs, frame_of(8'(f)));
          if (f > 0) check($sformatf("burst_gap%0d", f), gap + D, D + 1);
        end
      end
    join
    @(negedge clk);
    check("burst_idle", {txBusy, fifoCount}, {1'b0, 5'd0});

    push(8'hF7);
    for (int i = 0; i < 4; i++) push(8'hF7);
    repeat (14) @(posedge clk);
    #2;
    check("bit3_low", uartTx, 0);
    check("queued", fifoCount, 4);
    resetN = 1'b0;
    #1;
    check("async_reset", {uartTx, fifoCount}, {1'b1, 5'd0});
    @(negedge clk);
    resetN = 1'b1;
    all_hi = 1'b1;
    repeat (100) begin
      @(negedge clk);
      all_hi &= uartTx;
    end
    check("quiet_line", all_hi, 1);
    check("quiet_busy", {txBusy, fifoCount}, {1'b0, 5'd0});

`ifdef UART_TX_PARITY_EN
    push(8'h07);
    get_frame(obs, gap);
    check("parity_07", obs, frame_of(8'h07));
    check("parity_07_bit", obs[9*D], 1);
    @(negedge clk);
    push(8'h03);
    get_frame(obs, gap);
    check("parity_03", obs, frame_of(8'h03));
    check("parity_03_bit", obs[9*D], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
